rv_inst_encoder: RTL and testbench

- Instruction encoder for the single-cycle RV32I sim: takes symbolic instructions (op code, rd, rs1, rs2, imm) over a valid/ready handshake.
- Produces the 32-bit machine word the control decoder consumes, and writes it sequentially into instruction memory.
- Used by testbenches and the boot loader to build programs in IM without external hex files.
- Range-checks immediates and stops on the first illegal instruction.

---
 rtl/rv_inst_encoder_pkg.sv | 77 +++++++
 rtl/rv_inst_encoder_pack.sv | 118 +++++++++++
 rtl/rv_inst_encoder.sv | 145 ++++++++++++++
 tb/tb_rv_inst_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: symbolic op codes,
// base-ISA opcode/funct fields, error codes and encoder state/format types.
package rv_inst_encoder_pkg;

    localparam logic [4:0] OP_LUI   = 5'd0;
    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_XOR   = 5'd3;
    localparam logic [4:0] OP_OR    = 5'd4;
    localparam logic [4:0] OP_AND   = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SRL   = 5'd7;
    localparam logic [4:0] OP_SRA   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_LW    = 5'd11;
    localparam logic [4:0] OP_ADDI  = 5'd12;
    localparam logic [4:0] OP_XORI  = 5'd13;
    localparam logic [4:0] OP_ORI   = 5'd14;
    localparam logic [4:0] OP_ANDI  = 5'd15;
    localparam logic [4:0] OP_SLTI  = 5'd16;
    localparam logic [4:0] OP_SLTIU = 5'd17;
    localparam logic [4:0] OP_SLLI  = 5'd18;
    localparam logic [4:0] OP_SRLI  = 5'd19;
    localparam logic [4:0] OP_SRAI  = 5'd20;
    localparam logic [4:0] OP_SW    = 5'd21;
    localparam logic [4:0] OP_BEQ   = 5'd22;
    localparam logic [4:0] OP_BNE   = 5'd23;
    localparam logic [4:0] OP_BLT   = 5'd24;
    localparam logic [4:0] OP_BGE   = 5'd25;
    localparam logic [4:0] OP_BLTU  = 5'd26;
    localparam logic [4:0] OP_BGEU  = 5'd27;
    localparam logic [4:0] OP_JAL   = 5'd28;
    localparam logic [4:0] OP_JALR  = 5'd29;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_IMM   = 2'b01;
    localparam logic [1:0] ERR_SHAMT = 2'b10;
    localparam logic [1:0] ERR_OP    = 2'b11;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_RUN, ST_FULL, ST_ERR
    } state_e;

endpackage

// File: rtl/rv_inst_encoder_pack.sv
// Combinational packer: maps a symbolic instruction onto its RV32I machine
// word and flags out-of-range immediates, bad shift amounts and unknown ops.
module rv_inst_pack
    import rv_inst_encoder_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic [1:0]  err_code
);

    fmt_e               fmt;
    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic               imm_bad;
    logic signed [31:0] imm_s;

    assign imm_s = imm;

    // True when v is representable as a two's-complement value of 'bits' bits.
    function automatic logic fits_signed(input logic signed [31:0] v, input int bits);
        logic signed [31:0] hi;
        hi = v >>> (bits - 1);
        return (hi == 32'sd0) || (hi == -32'sd1);
    endfunction

    always_comb begin
        fmt = FMT_BAD;
        opc = 7'd0;
        f3  = 3'd0;
        f7  = F7_BASE;
        case (op)
            OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;    end
            OP_ADD:   begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_ADD;  end
            OP_SUB:   begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_ADD;  f7 = F7_ALT; end
            OP_XOR:   begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_XOR;  end
            OP_OR:    begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_OR;   end
            OP_AND:   begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_AND;  end
            OP_SLL:   begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_SLL;  end
            OP_SRL:   begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_SR;   end
            OP_SRA:   begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_SR;   f7 = F7_ALT; end
            OP_SLT:   begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_SLT;  end
            OP_SLTU:  begin fmt = FMT_R;  opc = OPC_RTYPE;  f3 = F3_SLTU; end
            OP_LW:    begin fmt = FMT_I;  opc = OPC_LOAD;   f3 = F3_W;    end
            OP_ADDI:  begin fmt = FMT_I;  opc = OPC_ITYPE;  f3 = F3_ADD;  end
            OP_XORI:  begin fmt = FMT_I;  opc = OPC_ITYPE;  f3 = F3_XOR;  end
            OP_ORI:   begin fmt = FMT_I;  opc = OPC_ITYPE;  f3 = F3_OR;   end
            OP_ANDI:  begin fmt = FMT_I;  opc = OPC_ITYPE;  f3 = F3_AND;  end
            OP_SLTI:  begin fmt = FMT_I;  opc = OPC_ITYPE;  f3 = F3_SLT;  end
            OP_SLTIU: begin fmt = FMT_I;  opc = OPC_ITYPE;  f3 = F3_SLTU; end
            OP_SLLI:  begin fmt = FMT_SH; opc = OPC_ITYPE;  f3 = F3_SLL;  end
            OP_SRLI:  begin fmt = FMT_SH; opc = OPC_ITYPE;  f3 = F3_SR;   end
            OP_SRAI:  begin fmt = FMT_SH; opc = OPC_ITYPE;  f3 = F3_SR;   f7 = F7_ALT; end
            OP_SW:    begin fmt = FMT_S;  opc = OPC_STORE;  f3 = F3_W;    end
            OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BEQ;  end
            OP_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BNE;  end
            OP_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLT;  end
            OP_BGE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGE;  end
            OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLTU; end
            OP_BGEU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGEU; end
            OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;    end
            OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR;   f3 = F3_ADD;  end
            default:  ;
        endcase
    end

    // Fields a format does not use are simply absent from its concatenation.
    always_comb begin
        word     = 32'd0;
        imm_bad  = 1'b0;
        illegal  = 1'b0;
        err_code = ERR_NONE;
        case (fmt)
            FMT_R: word = {f7, rs2, rs1, f3, rd, opc};
            FMT_I: begin
                word    = {imm[11:0], rs1, f3, rd, opc};
                imm_bad = !fits_signed(imm_s, 12);
            end
            FMT_SH: begin
                word = {f7, imm[4:0], rs1, f3, rd, opc};
                if (imm[31:5] != 27'd0) begin
                    illegal  = 1'b1;
                    err_code = ERR_SHAMT;
                end
            end
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                imm_bad = !fits_signed(imm_s, 12);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                imm_bad = !fits_signed(imm_s, 13) || imm[0];
            end
            FMT_U: begin
                word    = {imm[31:12], rd, opc};
                imm_bad = (imm[11:0] != 12'd0);
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                imm_bad = !fits_signed(imm_s, 21) || imm[0];
            end
            default: begin
                illegal  = 1'b1;
                err_code = ERR_OP;
            end
        endcase
        if (imm_bad) begin
            illegal  = 1'b1;
            err_code = ERR_IMM;
        end
    end

endmodule

// File: rtl/rv_inst_encoder.sv
// Instruction encoder top: valid/ready intake, run-control FSM and the
// registered IM write port with address/word counters.
module rv_inst_encoder
    import rv_inst_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 128,
    parameter int          CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             finish,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             im_we,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_e           state, state_nx;
    logic [31:0]      pk_word;
    logic             pk_illegal;
    logic [1:0]       pk_err;
    logic             accept, wr_en, set_err, done_nx, restart, last_word;
    logic [CNT_W-1:0] pending;

    logic             vld_p1;
    logic [31:0]      addr_p1;
    logic [31:0]      wdata_p1;
    logic             done_p1;
    logic             err_p1;
    logic [1:0]       err_code_p1;
    logic [CNT_W-1:0] cnt_p1;

    rv_inst_pack u_pack (
        .op       (in_op),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .imm      (in_imm),
        .word     (pk_word),
        .illegal  (pk_illegal),
        .err_code (pk_err)
    );

    // start has priority over an accept in the same cycle.
    assign in_ready = (state == ST_RUN) && !start;
    assign accept   = in_valid && in_ready;

    // A word still in flight on the write port is not yet in word_count.
    assign pending   = word_count + CNT_W'(vld_p1);
    assign last_word = (pending + CNT_W'(1)) == DEPTH_C;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        set_err  = 1'b0;
        done_nx  = 1'b0;
        restart  = 1'b0;
        case (state)
            ST_RUN: begin
                if (start) begin
                    restart = 1'b1;
                end else if (accept && pk_illegal) begin
                    state_nx = ST_ERR;
                    set_err  = 1'b1;
                end else begin
                    wr_en = accept;
                    if (accept && last_word) begin
                        state_nx = ST_FULL;
                        done_nx  = 1'b1;
                    end else if (finish) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nx = ST_RUN;
                    restart  = 1'b1;
                end
            end
        endcase
    end

    // p1: registered IM write port, status and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            addr_p1     <= BASE_ADDR;
            wdata_p1    <= 32'd0;
            done_p1     <= 1'b0;
            err_p1      <= 1'b0;
            err_code_p1 <= ERR_NONE;
            cnt_p1      <= '0;
        end else begin
            vld_p1  <= wr_en;
            done_p1 <= done_nx;
            if (wr_en) wdata_p1 <= pk_word;
            if (restart) begin
                addr_p1 <= BASE_ADDR;
                cnt_p1  <= '0;
            end else if (vld_p1) begin
                addr_p1 <= addr_p1 + 32'd4;
                cnt_p1  <= cnt_p1 + CNT_W'(1);
            end
            if (restart) begin
                err_p1      <= 1'b0;
                err_code_p1 <= ERR_NONE;
            end else if (set_err) begin
                err_p1      <= 1'b1;
                err_code_p1 <= pk_err;
            end
        end
    end

    assign im_we      = vld_p1;
    assign im_addr    = addr_p1;
    assign im_wdata   = wdata_p1;
    assign done       = done_p1;
    assign err        = err_p1;
    assign err_code   = err_code_p1;
    assign word_count = cnt_p1;
    assign busy       = (state == ST_RUN);

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Directed testbench for rv_inst_encoder (DEPTH = 4) with hand-encoded words.
module tb_rv_inst_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    localparam logic [4:0] T_LUI = 5'd0, T_ADD = 5'd1, T_SUB = 5'd2, T_LW = 5'd11;
    localparam logic [4:0] T_ADDI = 5'd12, T_SLLI = 5'd18, T_SRAI = 5'd20, T_SW = 5'd21;
    localparam logic [4:0] T_BEQ = 5'd22, T_JAL = 5'd28, T_BAD = 5'd31;

    logic             clk = 1'b0;
    logic             rst, start, finish, in_valid, in_ready;
    logic [4:0]       in_op, in_rd, in_rs1, in_rs2;
    logic [31:0]      in_imm;
    logic             im_we, busy, done, err;
    logic [31:0]      im_addr, im_wdata;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] word_count;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    rv_inst_encoder #(.BASE_ADDR(32'h0), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .word_count(word_count)
    );

    // IM model: log every write and every done pulse
    always @(negedge clk) begin
        if (im_we) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic put(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_finish;
        finish = 1'b1; @(negedge clk); finish = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (im_we !== 1'b0) $display("FAIL rst_im_we: got %b want 0", im_we); else n_pass++;
        n_checks++; if (im_addr !== 32'h0) $display("FAIL rst_im_addr: got %h want 0", im_addr); else n_pass++;
        n_checks++; if (im_wdata !== 32'h0) $display("FAIL rst_im_wdata: got %h want 0", im_wdata); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (err !== 1'b0 || err_code !== 2'b00) $display("FAIL rst_err: got %b/%b want 0/00", err, err_code); else n_pass++;
        n_checks++; if (word_count !== 8'd0) $display("FAIL rst_count: got %0d want 0", word_count); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", in_ready); else n_pass++;
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_alu;
        int b = wr_addr.size();
        int d = done_cnt;
        pulse_start; #1;
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL alu_run: got busy %b ready %b want 1 1", busy, in_ready); else n_pass++;
        put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
        put(T_ADD, 5'd3, 5'd1, 5'd2, 32'd0);
        finish = 1'b1;
        put(T_SUB, 5'd3, 5'd1, 5'd2, 32'd0);
        finish = 1'b0;
        idle(4);
        n_checks++; if (wr_addr.size() - b !== 3) $display("FAIL alu_nwrites: got %0d want 3", wr_addr.size() - b); else n_pass++;
        n_checks++; if (wr_data[b] !== 32'h00500093 || wr_addr[b] !== 32'h0) $display("FAIL alu_addi: got %h@%h want 00500093@0", wr_data[b], wr_addr[b]); else n_pass++;
        n_checks++; if (wr_data[b+1] !== 32'h002081B3 || wr_addr[b+1] !== 32'h4) $display("FAIL alu_add: got %h@%h want 002081b3@4", wr_data[b+1], wr_addr[b+1]); else n_pass++;
        n_checks++; if (wr_data[b+2] !== 32'h402081B3 || wr_addr[b+2] !== 32'h8) $display("FAIL alu_sub: got %h@%h want 402081b3@8", wr_data[b+2], wr_addr[b+2]); else n_pass++;
        n_checks++; if (word_count !== 8'd3) $display("FAIL alu_count: got %0d want 3", word_count); else n_pass++;
        n_checks++; if (done_cnt - d !== 1) $display("FAIL alu_done: got %0d pulses want 1", done_cnt - d); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL alu_idle: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_mem_full;
        int b = wr_addr.size();
        int d = done_cnt;
        pulse_start;
        put(T_LW, 5'd5, 5'd2, 5'd0, 32'd8);
        put(T_SW, 5'd7, 5'd2, 5'd5, 32'd12);
        put(T_LUI, 5'd5, 5'd3, 5'd3, 32'h12345000);
        put(T_SRAI, 5'd4, 5'd3, 5'd9, 32'd2);
        idle(3);
        pulse_finish;
        put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
        idle(3);
        n_checks++; if (wr_addr.size() - b !== 4) $display("FAIL mem_nwrites: got %0d want 4", wr_addr.size() - b); else n_pass++;
        n_checks++; if (wr_data[b] !== 32'h00812283) $display("FAIL mem_lw: got %h want 00812283", wr_data[b]); else n_pass++;
        n_checks++; if (wr_data[b+1] !== 32'h00512623) $display("FAIL mem_sw: got %h want 00512623", wr_data[b+1]); else n_pass++;
        n_checks++; if (wr_data[b+2] !== 32'h123452B7) $display("FAIL mem_lui: got %h want 123452b7", wr_data[b+2]); else n_pass++;
        n_checks++; if (wr_data[b+3] !== 32'h4021D213) $display("FAIL mem_srai: got %h want 4021d213", wr_data[b+3]); else n_pass++;
        n_checks++; if (done_cnt - d !== 1) $display("FAIL mem_done: got %0d pulses want 1", done_cnt - d); else n_pass++;
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL mem_full: got ready %b busy %b want 0 0", in_ready, busy); else n_pass++;
        n_checks++; if (word_count !== 8'd4) $display("FAIL mem_count: got %0d want 4", word_count); else n_pass++;
    endtask

    task automatic test_branch_err;
        int b = wr_addr.size();
        int d = done_cnt;
        pulse_start; #1;
        n_checks++; if (im_addr !== 32'h0 || word_count !== 8'd0) $display("FAIL br_restart: got %h/%0d want 0/0", im_addr, word_count); else n_pass++;
        put(T_BEQ, 5'd9, 5'd1, 5'd2, 32'd8);
        put(T_JAL, 5'd1, 5'd0, 5'd7, 32'd16);
        put(T_BEQ, 5'd0, 5'd1, 5'd2, 32'd7);
        idle(3);
        n_checks++; if (wr_addr.size() - b !== 2) $display("FAIL br_nwrites: got %0d want 2", wr_addr.size() - b); else n_pass++;
        n_checks++; if (wr_data[b] !== 32'h00208463) $display("FAIL br_beq: got %h want 00208463", wr_data[b]); else n_pass++;
        n_checks++; if (wr_data[b+1] !== 32'h010000EF) $display("FAIL br_jal: got %h want 010000ef", wr_data[b+1]); else n_pass++;
        n_checks++; if (err !== 1'b1 || err_code !== 2'b01) $display("FAIL br_err: got %b/%b want 1/01", err, err_code); else n_pass++;
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL br_stop: got ready %b busy %b want 0 0", in_ready, busy); else n_pass++;
        n_checks++; if (done_cnt - d !== 0) $display("FAIL br_done: got %0d pulses want 0", done_cnt - d); else n_pass++;
    endtask

    task automatic test_err_codes;
        int b;
        pulse_start; #1;
        n_checks++; if (err !== 1'b0 || im_addr !== 32'h0 || busy !== 1'b1) $display("FAIL ec_clear: got err %b addr %h busy %b want 0 0 1", err, im_addr, busy); else n_pass++;
        put(T_SLLI, 5'd1, 5'd1, 5'd0, 32'd32);
        idle(2);
        n_checks++; if (err !== 1'b1 || err_code !== 2'b10) $display("FAIL ec_shamt: got %b/%b want 1/10", err, err_code); else n_pass++;
        pulse_start;
        put(T_BAD, 5'd1, 5'd1, 5'd1, 32'd0);
        idle(2);
        n_checks++; if (err !== 1'b1 || err_code !== 2'b11) $display("FAIL ec_op: got %b/%b want 1/11", err, err_code); else n_pass++;
        b = wr_addr.size();
        pulse_start;
        put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
        put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048);
        idle(2);
        n_checks++; if (wr_data[b] !== 32'h80000093 || wr_addr.size() - b !== 1) $display("FAIL ec_imm_min: got %h n=%0d want 80000093 n=1", wr_data[b], wr_addr.size() - b); else n_pass++;
        n_checks++; if (err !== 1'b1 || err_code !== 2'b01) $display("FAIL ec_imm_max: got %b/%b want 1/01", err, err_code); else n_pass++;
        pulse_start; #1;
        n_checks++; if (err !== 1'b0 || err_code !== 2'b00 || im_addr !== 32'h0) $display("FAIL ec_reclear: got %b/%b addr %h want 0/00 0", err, err_code, im_addr); else n_pass++;
        pulse_finish;
        idle(2);
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_w[4] = '{32'h00000093, 32'h00100093, 32'h00200093, 32'h00300093};
        int b = wr_addr.size();
        int d = done_cnt;
        pulse_start;
        for (int i = 0; i < 6; i++) put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'(i));
        idle(4);
        n_checks++; if (wr_addr.size() - b !== 4) $display("FAIL b2b_nwrites: got %0d want 4", wr_addr.size() - b); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_addr[b+i] !== 32'(4 * i) || wr_data[b+i] !== exp_w[i])
                $display("FAIL b2b_word%0d: got %h@%h want %h@%h", i, wr_data[b+i], wr_addr[b+i], exp_w[i], 32'(4 * i));
            else n_pass++;
        end
        n_checks++; if (done_cnt - d !== 1) $display("FAIL b2b_done: got %0d pulses want 1", done_cnt - d); else n_pass++;
        n_checks++; if (in_ready !== 1'b0 || word_count !== 8'd4) $display("FAIL b2b_full: got ready %b count %0d want 0 4", in_ready, word_count); else n_pass++;
    endtask

    task automatic test_start_in_run;
        int b = wr_addr.size();
        pulse_start;
        put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
        start = 1'b1; in_valid = 1'b1; in_imm = 32'd9; #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL sir_ready: got %b want 0", in_ready); else n_pass++;
        @(negedge clk);
        start = 1'b0;
        put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd2);
        idle(3);
        n_checks++; if (wr_addr.size() - b !== 2) $display("FAIL sir_nwrites: got %0d want 2", wr_addr.size() - b); else n_pass++;
        n_checks++; if (wr_data[b] !== 32'h00100093 || wr_addr[b] !== 32'h0) $display("FAIL sir_first: got %h@%h want 00100093@0", wr_data[b], wr_addr[b]); else n_pass++;
        n_checks++; if (wr_data[b+1] !== 32'h00200093 || wr_addr[b+1] !== 32'h0) $display("FAIL sir_after: got %h@%h want 00200093@0", wr_data[b+1], wr_addr[b+1]); else n_pass++;
        n_checks++; if (word_count !== 8'd1 || busy !== 1'b1) $display("FAIL sir_count: got %0d busy %b want 1 1", word_count, busy); else n_pass++;
        pulse_finish;
        idle(2);
    endtask

    task automatic test_rst_mid;
        int b = wr_addr.size();
        pulse_start;
        put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
        put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd2);
        put(T_ADDI, 5'd1, 5'd0, 5'd0, 32'd3);
        #1;
        n_checks++; if (im_we !== 1'b1 || word_count !== 8'd2) $display("FAIL rm_pre: got we %b count %0d want 1 2", im_we, word_count); else n_pass++;
        rst = 1'b1; #1;
        n_checks++; if (im_we !== 1'b0 || im_addr !== 32'h0 || im_wdata !== 32'h0) $display("FAIL rm_port: got %b %h %h want 0 0 0", im_we, im_addr, im_wdata); else n_pass++;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || word_count !== 8'd0) $display("FAIL rm_ctrl: got busy %b ready %b count %0d want 0 0 0", busy, in_ready, word_count); else n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        n_checks++; if (wr_addr.size() - b !== 3 || busy !== 1'b0) $display("FAIL rm_after: got %0d writes busy %b want 3 0", wr_addr.size() - b, busy); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_op = 5'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
        test_reset;
        test_alu;
        test_mem_full;
        test_branch_err;
        test_err_codes;
        test_back_to_back;
        test_start_in_run;
        test_rst_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
